// File: rtl/uart_word_rx.sv
// UART 8N1 receiver that packs WORD_BYTES bytes (LSB byte first) into one word.
// Partial words are dropped on a framing error or after a period of line inactivity.
module uart_word_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int WORD_BYTES   = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    output logic [8*WORD_BYTES-1:0] data,
    output logic                    recv_done,
    output logic                    frame_err,
    output logic                    timeout,
    output logic                    busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int TW           = $clog2(TO_LIMIT + 1);
    localparam int BW           = $clog2(WORD_BYTES + 1);
    localparam int DW           = 8 * WORD_BYTES;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t          state_q, state_d;
    logic            rx_m, rx_s;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DW-1:0]   asm_q, asm_d;
    logic [DW-1:0]   data_q, data_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            done_d, ferr_d, tmo_d;

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        data_d     = data_q;
        tmo_cnt_d  = '0;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        tmo_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // Inactivity counter only runs while a partial word is pending.
                if (byte_cnt_q != '0) begin
                    if (tmo_cnt_q == TW'(TO_LIMIT - 1)) begin
                        byte_cnt_d = '0;
                        tmo_d      = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                if (!rx_s) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt_q == CW'(HALF_BIT - 1)) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        for (int i = 0; i < WORD_BYTES; i++)
                            if (byte_cnt_q == BW'(i)) asm_d[i*8 +: 8] = shift_q;
                        if (byte_cnt_q == BW'(WORD_BYTES - 1)) begin
                            data_d     = asm_d;
                            done_d     = 1'b1;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        ferr_d     = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            data_q     <= '0;
            tmo_cnt_q  <= '0;
            recv_done  <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            data_q     <= data_d;
            tmo_cnt_q  <= tmo_cnt_d;
            recv_done  <= done_d;
            frame_err  <= ferr_d;
            timeout    <= tmo_d;
        end
    end

    assign data = data_q;
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx at 16 clocks per bit (CLK_FREQ=1600, BAUD=100).
// Line is driven on falling clock edges; outputs are sampled 1 time unit after rising edges.
module tb_uart_word_rx;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [31:0] data;
    logic        recv_done, frame_err, timeout, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0, ferr_cnt = 0, tmo_cnt = 0, busy_cnt = 0;
    int done_cyc = 0, frame_start_cyc = 0, busy_low = 0;

    uart_word_rx #(
        .CLK_FREQ(1600), .BAUD(100), .WORD_BYTES(4), .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data),
        .recv_done(recv_done), .frame_err(frame_err),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (recv_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (frame_err) ferr_cnt++;
        if (timeout)   tmo_cnt++;
        if (busy)      busy_cnt++;
        if ((recv_done && frame_err) || (timeout && (recv_done || frame_err))) begin
            errors++;
            $display("FAIL strobe_overlap: done=%0b ferr=%0b tmo=%0b, required at most one", recv_done, frame_err, timeout);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        done_cnt = 0; ferr_cnt = 0; tmo_cnt = 0; busy_cnt = 0; busy_low = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        frame_start_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == 4) begin
                repeat (CPB / 2) @(negedge clk);
                if (!busy) busy_low++;
                repeat (CPB / 2) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (data !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h, required 00000000", data);
        end
        checks++;
        if ({recv_done, frame_err, timeout, busy} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes: got %b, required 0000", {recv_done, frame_err, timeout, busy});
        end
        rst = 1'b0;
        clear_counts();
        repeat (200) @(negedge clk);
        checks++;
        if (done_cnt + ferr_cnt + tmo_cnt + busy_cnt !== 0) begin
            errors++; $display("FAIL idle_activity: done=%0d ferr=%0d tmo=%0d busy=%0d, required all 0", done_cnt, ferr_cnt, tmo_cnt, busy_cnt);
        end
        checks++;
        if (data !== 32'h0) begin
            errors++; $display("FAIL idle_data: got %h, required 00000000", data);
        end
    endtask

    task automatic test_word();
        clear_counts();
        send_frame(8'hFF, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'h00, 1'b1);
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL word_done_count: got %0d, required 1", done_cnt);
        end
        // Start edge to strobe: 2 sync + 1 detect + 8 half-bit + 144 bit-times = 155 clocks.
        checks++;
        if (done_cyc - frame_start_cyc !== 155) begin
            errors++; $display("FAIL word_latency: got %0d, required 155", done_cyc - frame_start_cyc);
        end
        checks++;
        if (data !== 32'h0000FFFF) begin
            errors++; $display("FAIL word_data: got %h, required 0000ffff", data);
        end
        checks++;
        if (busy_low !== 0) begin
            errors++; $display("FAIL word_busy: %0d frames idle mid-frame, required 0", busy_low);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy: got %b, required 0", busy);
        end
        checks++;
        if (done_cnt + ferr_cnt + tmo_cnt !== 0) begin
            errors++; $display("FAIL glitch_strobes: done=%0d ferr=%0d tmo=%0d, required 0", done_cnt, ferr_cnt, tmo_cnt);
        end
        send_word(32'h78563412);
        checks++;
        if (data !== 32'h78563412 || done_cnt !== 1) begin
            errors++; $display("FAIL glitch_word: got %h done=%0d, required 78563412 done=1", data, done_cnt);
        end
    endtask

    task automatic test_frame_err();
        clear_counts();
        send_frame(8'hAA, 1'b1);
        send_frame(8'h55, 1'b0);
        repeat (100 - CPB) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL ferr_wait_high_busy: got %b, required 1", busy);
        end
        checks++;
        if (ferr_cnt !== 1) begin
            errors++; $display("FAIL ferr_count: got %0d, required 1", ferr_cnt);
        end
        checks++;
        if (data !== 32'h78563412) begin
            errors++; $display("FAIL ferr_data_held: got %h, required 78563412", data);
        end
        rx = 1'b1;
        repeat (40) @(negedge clk);
        send_word(32'h44332211);
        checks++;
        if (data !== 32'h44332211) begin
            errors++; $display("FAIL ferr_next_word: got %h, required 44332211", data);
        end
        checks++;
        if (done_cnt !== 1 || ferr_cnt !== 1) begin
            errors++; $display("FAIL ferr_after: done=%0d ferr=%0d, required 1 and 1", done_cnt, ferr_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_frame(8'hAB, 1'b1);
        send_frame(8'hCD, 1'b1);
        repeat (20 * CPB + 5) @(negedge clk);
        checks++;
        if (tmo_cnt !== 1) begin
            errors++; $display("FAIL timeout_count: got %0d, required 1", tmo_cnt);
        end
        checks++;
        if (data !== 32'h44332211 || done_cnt !== 0) begin
            errors++; $display("FAIL timeout_data: got %h done=%0d, required 44332211 done=0", data, done_cnt);
        end
        send_word(32'h04030201);
        checks++;
        if (data !== 32'h04030201) begin
            errors++; $display("FAIL timeout_next_word: got %h, required 04030201", data);
        end
        checks++;
        if (done_cnt !== 1 || tmo_cnt !== 1) begin
            errors++; $display("FAIL timeout_after: done=%0d tmo=%0d, required 1 and 1", done_cnt, tmo_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b3;
        b3 = 8'h5A;
        clear_counts();
        send_frame(8'hC3, 1'b1);
        send_frame(8'h3C, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b3[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b3[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (data !== 32'h0 || {recv_done, frame_err, timeout, busy} !== 4'b0) begin
            errors++; $display("FAIL midreset_outputs: data=%h strobes/busy=%b, required 0", data, {recv_done, frame_err, timeout, busy});
        end
        rst = 1'b0;
        rx  = 1'b1;
        clear_counts();
        repeat (200) @(negedge clk);
        checks++;
        if (done_cnt + ferr_cnt + tmo_cnt !== 0) begin
            errors++; $display("FAIL midreset_quiet: done=%0d ferr=%0d tmo=%0d, required 0", done_cnt, ferr_cnt, tmo_cnt);
        end
        send_word(32'hDEADBEEF);
        checks++;
        if (data !== 32'hDEADBEEF || done_cnt !== 1) begin
            errors++; $display("FAIL midreset_word: got %h done=%0d, required deadbeef done=1", data, done_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_word();
        test_glitch();
        test_frame_err();
        test_timeout();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
